// File: rtl/spi_regfile_rw_if.sv
// SPI pin bundle for spi_regfile_rw: SCLK/nCS/COPI from the controller,
// CIPO/cipo_oe back from the target. master = pin driver, slave = target.
interface spi_regfile_rw_if;
  logic SCLK;
  logic nCS;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (
    output SCLK, nCS, COPI,
    input  CIPO, cipo_oe
  );

  modport slave (
    input  SCLK, nCS, COPI,
    output CIPO, cipo_oe
  );
endinterface

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 target register file, oversampled on clk, with CIPO readback.
// Ports: clk, rst (sync, active-high); spi (slave: SCLK nCS COPI CIPO
// cipo_oe); regs_flat (reg k at [k*DATA_W +: DATA_W]); wr_pulse, wr_addr,
// addr_err. Frame: rw, ADDR_W addr bits, DATA_W data bits, MSB first.
// Define SPI_BURST_EN for multi-word frames with auto address increment.
module spi_regfile_rw #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_rw_if.slave            spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       addr_err
);

`ifdef SPI_BURST_EN
  localparam bit L_BURST = 1'b1;
`else
  localparam bit L_BURST = 1'b0;
`endif

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] L_CMD_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] L_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0] L_NREG = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE, S_CMD, S_DATA, S_DONE
  } state_t;

  state_t r_state, w_state_nx;

  logic [SYNC_STAGES-1:0] r_sclk_s, r_ncs_s, r_copi_s;
  logic r_sclk_d, r_ncs_d;
  logic w_sclk, w_ncs, w_copi;
  logic w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_cmd_sh;
  logic [DATA_W-2:0] r_wr_sh;
  logic [DATA_W-1:0] r_rd_sh;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_act;
  logic              r_seen;
  logic              r_wr_pulse;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_cmd_done, w_word_done;
  logic [ADDR_W:0]   w_cmd;
  logic [DATA_W-1:0] w_wr_word;
  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_ld_ok, w_cur_ok;
  logic [DATA_W-1:0] w_ld_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_ncs_s  <= '1;
      r_copi_s <= '0;
      r_sclk_d <= 1'b0;
      r_ncs_d  <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], spi.SCLK};
      r_ncs_s  <= {r_ncs_s[SYNC_STAGES-2:0], spi.nCS};
      r_copi_s <= {r_copi_s[SYNC_STAGES-2:0], spi.COPI};
      r_sclk_d <= w_sclk;
      r_ncs_d  <= w_ncs;
    end
  end

  assign w_sclk = r_sclk_s[SYNC_STAGES-1];
  assign w_ncs  = r_ncs_s[SYNC_STAGES-1];
  assign w_copi = r_copi_s[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ncs_rise  = w_ncs & ~r_ncs_d;
  assign w_ncs_fall  = ~w_ncs & r_ncs_d;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // nCS edges override everything; a fresh fall wins over completion.
  always_comb begin
    w_state_nx  = r_state;
    w_cmd_done  = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_CMD:
        if (w_sclk_rise && r_cnt == L_CMD_LAST) begin
          w_cmd_done = 1'b1;
          w_state_nx = S_DATA;
        end
      S_DATA:
        if (w_sclk_rise && r_cnt == L_DATA_LAST) begin
          w_word_done = 1'b1;
          w_state_nx  = L_BURST ? S_DATA : S_DONE;
        end
      S_DONE: ;
      default: w_state_nx = S_IDLE;
    endcase
    if (w_ncs_rise) begin
      w_state_nx  = S_IDLE;
      w_cmd_done  = 1'b0;
      w_word_done = 1'b0;
    end
    if (w_ncs_fall) begin
      w_state_nx  = S_CMD;
      w_cmd_done  = 1'b0;
      w_word_done = 1'b0;
    end
  end

  assign w_cmd     = {r_cmd_sh, w_copi};
  assign w_wr_word = {r_wr_sh, w_copi};

  // Readback source: the just-decoded address at command end, or the
  // next address when a burst rolls over to a new word.
  assign w_ld_addr = (r_state == S_CMD) ? w_cmd[ADDR_W-1:0]
                                        : r_addr + 1'b1;
  assign w_ld_ok   = {1'b0, w_ld_addr} < L_NREG;
  assign w_cur_ok  = {1'b0, r_addr} < L_NREG;
  assign w_ld_val  = w_ld_ok ? r_regs[w_ld_addr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_cmd_sh   <= '0;
      r_wr_sh    <= '0;
      r_rd_sh    <= '0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_rd_act   <= 1'b0;
      r_seen     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_addr_err <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      r_addr_err <= 1'b0;
      if (w_ncs_fall || w_ncs_rise) begin
        r_cnt    <= '0;
        r_seen   <= 1'b0;
        r_rd_act <= 1'b0;
        r_rd_sh  <= '0;
      end else if (r_state == S_CMD && w_sclk_rise) begin
        r_cmd_sh <= w_cmd[ADDR_W-1:0];
        r_cnt    <= r_cnt + 1'b1;
        if (w_cmd_done) begin
          r_cnt    <= '0;
          r_rw     <= w_cmd[ADDR_W];
          r_addr   <= w_cmd[ADDR_W-1:0];
          r_seen   <= 1'b0;
          r_rd_act <= ~w_cmd[ADDR_W];
          r_rd_sh  <= w_cmd[ADDR_W] ? '0 : w_ld_val;
        end
      end else if (r_state == S_DATA && w_sclk_rise) begin
        r_wr_sh <= w_wr_word[DATA_W-2:0];
        r_seen  <= 1'b1;
        r_cnt   <= r_cnt + 1'b1;
        if (w_word_done) begin
          r_cnt <= '0;
          if (!w_cur_ok) begin
            r_addr_err <= 1'b1;
          end else if (r_rw) begin
            r_regs[r_addr[IDX_W-1:0]] <= w_wr_word;
            r_wr_pulse <= 1'b1;
            r_wr_addr  <= r_addr;
          end
          if (L_BURST) begin
            r_addr <= r_addr + 1'b1;
            r_seen <= 1'b0;
            if (!r_rw) r_rd_sh <= w_ld_val;
          end
        end
      end else if (r_state == S_DATA && w_sclk_fall &&
                   r_seen && !r_rw) begin
        r_rd_sh <= {r_rd_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++)
      regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
  end

  assign spi.cipo_oe = r_rd_act & ~w_ncs;
  assign spi.CIPO    = spi.cipo_oe & r_rd_sh[DATA_W-1];
  assign wr_pulse    = r_wr_pulse;
  assign wr_addr     = r_wr_addr;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Self-checking bench for spi_regfile_rw: directed cases plus random
// frames against an array-based register-file model.
module tb_spi_regfile_rw;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int NR = 5;
  localparam int HALF = 8;

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NR*DW-1:0] regs_flat;
  logic wr_pulse;
  logic [AW-1:0] wr_addr;
  logic addr_err;

  spi_regfile_rw_if bus();

  spi_regfile_rw #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .spi(bus),
    .regs_flat(regs_flat), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  logic [7:0] m_regs [NR];
  int m_wp = 0, m_ae = 0;
  logic [6:0] m_wa = '0;
  int n_wp = 0, n_ae = 0;
  int n_chk = 0, n_fail = 0;

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) n_wp++;
    if (addr_err === 1'b1) n_ae++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = m_regs[k];
    return f;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_wa = '0;
  endtask

  // Model of one frame carrying nw complete words.
  task automatic m_frame(input logic rw, input logic [6:0] a,
                         input logic [31:0] words, input int nw,
                         output logic [7:0] rexp);
    int lim;
    logic [6:0] ad;
    lim = BURST ? nw : ((nw > 0) ? 1 : 0);
    rexp = '0;
    for (int k = 0; k < lim; k++) begin
      ad = a + 7'(k);
      if (int'(ad) < NR) begin
        if (k == 0) rexp = m_regs[ad];
        if (rw) begin
          m_regs[ad] = words[31-8*k -: 8];
          m_wp++;
          m_wa = ad;
        end
      end else begin
        m_ae++;
      end
    end
  endtask

  task automatic xfer(input logic [39:0] w, input int nbits,
                      input bit end_cs, input logic exp_oe,
                      output logic [31:0] rd, output bit oe_ok);
    rd = '0;
    oe_ok = 1'b1;
    bus.nCS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.COPI = w[39-i];
      repeat (HALF) @(negedge clk);
      if (i >= 8) begin
        rd = {rd[30:0], bus.CIPO};
        if (bus.cipo_oe !== exp_oe) oe_ok = 1'b0;
      end
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (end_cs) begin
      bus.nCS = 1'b1;
      bus.COPI = 1'b0;
      repeat (2*HALF) @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic rw,
                     input logic [6:0] a, input logic [31:0] words,
                     input int nw);
    logic [31:0] rd;
    logic [7:0] rexp;
    bit ok;
    xfer({rw, a, words}, 8 + 8*nw, 1'b1, ~rw, rd, ok);
    m_frame(rw, a, words, nw, rexp);
    chk({tag, ".regs"}, 64'(regs_flat), 64'(m_flat()));
    chk({tag, ".wr_pulses"}, 64'(n_wp), 64'(m_wp));
    chk({tag, ".addr_errs"}, 64'(n_ae), 64'(m_ae));
    chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_wa));
    chk({tag, ".oe_in_data"}, 64'(ok), 64'(1));
    chk({tag, ".oe_after_cs"}, 64'(bus.cipo_oe), 64'(0));
    if (!rw && nw == 1) chk({tag, ".rdata"}, 64'(rd[7:0]), 64'(rexp));
  endtask

  initial begin
    logic [31:0] rd;
    bit ok;
    logic rw;
    logic [6:0] a;

    bus.SCLK = 1'b0;
    bus.nCS  = 1'b1;
    bus.COPI = 1'b0;
    rst = 1'b1;
    m_clear();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("reset.regs", 64'(regs_flat), 64'(0));
    chk("reset.wr_addr", 64'(wr_addr), 64'(0));
    chk("reset.cipo", 64'(bus.CIPO), 64'(0));
    chk("reset.oe", 64'(bus.cipo_oe), 64'(0));
    chk("reset.pulses", 64'(n_wp + n_ae), 64'(0));

    run("wr2", 1'b1, 7'h02, 32'hA500_0000, 1);
    chk("wr2.byte", 64'(regs_flat[23:16]), 64'(8'hA5));
    run("wr4", 1'b1, 7'h04, 32'h3C00_0000, 1);
    run("rd4", 1'b0, 7'h04, 32'h0, 1);
    run("wr5_oor", 1'b1, 7'h05, 32'hFF00_0000, 1);
    run("rd7f_oor", 1'b0, 7'h7F, 32'h0, 1);

    xfer({1'b1, 7'h01, 32'h9900_0000}, 10, 1'b1, 1'b0, rd, ok);
    chk("abort.regs", 64'(regs_flat), 64'(m_flat()));
    chk("abort.pulses", 64'(n_wp), 64'(m_wp));
    run("wr1", 1'b1, 7'h01, 32'h1100_0000, 1);

    run("wr0", 1'b1, 7'h00, 32'hFF00_0000, 1);
    xfer({1'b0, 7'h00, 32'h0}, 12, 1'b0, 1'b1, rd, ok);
    chk("midrd.bits", 64'(rd[3:0]), 64'(4'hF));
    chk("midrd.oe", 64'(bus.cipo_oe), 64'(1));
    chk("midrd.cipo", 64'(bus.CIPO), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    chk("rstmid.regs", 64'(regs_flat), 64'(0));
    chk("rstmid.cipo", 64'(bus.CIPO), 64'(0));
    chk("rstmid.oe", 64'(bus.cipo_oe), 64'(0));
    chk("rstmid.wr_addr", 64'(wr_addr), 64'(0));
    bus.nCS = 1'b1;
    bus.SCLK = 1'b0;
    repeat (2*HALF) @(negedge clk);
    run("post_rst_wr3", 1'b1, 7'h03, 32'h5A00_0000, 1);
    run("post_rst_rd3", 1'b0, 7'h03, 32'h0, 1);

    run("burst", 1'b1, 7'h01, 32'h1122_3300, 3);

    for (int n = 0; n < 30; n++) begin
      rw = 1'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
      run("rand", rw, a, {8'($urandom), 24'h0}, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
